uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver, mid-bit sampling, 1-deep holding register.
// Define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte;
  logic        deliver, frame_err;
  logic        fall;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  // bits enter at the top, so a short frame ends up MSB-aligned
  assign rx_byte = shift_q >> (8 - DATA_BITS);
  assign fall    = rx_prev_q & ~rx_sync_q;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) par_err_q <= 1'b0;
    else          par_err_q <= par_err_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          // a line back high at mid-start was only a glitch
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          par_err_d = rx_sync_q ^ (^rx_byte);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          if (rx_sync_q && !par_err_q) deliver = 1'b1;
          else                         frame_err = 1'b1;
`else
          if (rx_sync_q) deliver = 1'b1;
          else           frame_err = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_err;
      overrun_o   <= deliver & valid_o & ~ready_i;
      // a consume in the same cycle frees the slot for the new byte
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= rx_byte;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
